// File: rtl/step_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_pulse_gen
//   Turns a bouncing pushbutton (manual step) and a free-running auto-step
//   timer into a single-cycle step strobe for a datapath. It also counts the
//   strobes it issues.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   reset       asynchronous, active-low reset
//   btn_in      raw asynchronous pushbutton
//   run_en      asynchronous slide switch; 1 selects auto-step mode
//   rate_sel    auto period select: AUTO_DIV << rate_sel cycles
//   step_pulse  registered one-cycle step strobe
//   btn_level   registered debounced button level
//   step_count  number of strobes issued (wraps silently)
// ---------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int DB_COUNT = 1000000,
    parameter int AUTO_DIV = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_in,
    input  logic        run_en,
    input  logic [1:0]  rate_sel,
    output logic        step_pulse,
    output logic        btn_level,
    output logic [15:0] step_count
);

    localparam int DB_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    // The tick counter must cover the slowest period (8x).
    localparam int TICK_W = $clog2(AUTO_DIV * 8 + 1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } db_state_e;

    // Two-flop synchronizers
    logic btn_meta_q, btn_sync_q;
    logic run_meta_q, run_sync_q;

    db_state_e         state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              btn_level_q, btn_level_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TICK_W-1:0] period_m1;
    logic              step_pulse_q, step_pulse_d;
    logic [15:0]       step_count_q, step_count_d;
    logic              manual_evt, auto_evt;

    // Debounce FSM next state
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            LOW: begin
                if (btn_sync_q) begin
                    state_d  = ARM_HI;
                    db_cnt_d = '0;
                end
            end
            ARM_HI: begin
                if (!btn_sync_q) begin
                    state_d  = LOW;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DB_COUNT - 1)) begin
                    state_d  = HIGH;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HIGH: begin
                if (!btn_sync_q) begin
                    state_d  = ARM_LO;
                    db_cnt_d = '0;
                end
            end
            ARM_LO: begin
                if (btn_sync_q) begin
                    state_d  = HIGH;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DB_COUNT - 1)) begin
                    state_d  = LOW;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = LOW;
                db_cnt_d = '0;
            end
        endcase
    end

    // The level is registered from the next state, so it tracks the FSM
    // without a cycle of lag. A press is the cycle that level is about to
    // rise. A release never makes an event.
    assign btn_level_d = (state_d == HIGH) || (state_d == ARM_LO);
    assign manual_evt  = btn_level_d && !btn_level_q;

    // Auto-step timer. The compare is ">=" so that a rate_sel change to a
    // shorter period fires at once instead of wrapping the counter.
    assign period_m1 = (TICK_W'(AUTO_DIV) << rate_sel) - TICK_W'(1);

    always_comb begin
        tick_d   = '0;
        auto_evt = 1'b0;
        if (run_sync_q) begin
            if (tick_q >= period_m1) begin
                auto_evt = 1'b1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // Coincident manual and auto events merge into one strobe.
    assign step_pulse_d = manual_evt || auto_evt;
    assign step_count_d = step_pulse_d ? step_count_q + 16'd1 : step_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            run_meta_q   <= 1'b0;
            run_sync_q   <= 1'b0;
            state_q      <= LOW;
            db_cnt_q     <= '0;
            btn_level_q  <= 1'b0;
            tick_q       <= '0;
            step_pulse_q <= 1'b0;
            step_count_q <= 16'h0000;
        end else begin
            btn_meta_q   <= btn_in;
            btn_sync_q   <= btn_meta_q;
            run_meta_q   <= run_en;
            run_sync_q   <= run_meta_q;
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            btn_level_q  <= btn_level_d;
            tick_q       <= tick_d;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign btn_level  = btn_level_q;
    assign step_count = step_count_q;

endmodule
